// File: rtl/svm_kernel_sched_if.sv
// ---------------------------------------------------------------------------
// svm_kernel_sched_if
// Bundles the classification-control, kernel-engine and alpha-memory signals
// of the SVM kernel scheduler.
//   Parameters : IDX_W (support-vector index width), ACC_W (score width)
//   master     : drives start, stall_MEM, bias, kern_done, kern_result,
//                alpha_data; observes everything the scheduler drives
//   slave      : the scheduler side (svm_kernel_sched)
// ---------------------------------------------------------------------------
interface svm_kernel_sched_if #(
  parameter int IDX_W = 4,
  parameter int ACC_W = 40
);
  logic             start;
  logic             stall_MEM;
  logic             kern_start;
  logic [IDX_W-1:0] kern_sv_idx;
  logic             kern_done;
  logic [15:0]      kern_result;
  logic [IDX_W-1:0] alpha_addr;
  logic [15:0]      alpha_data;
  logic             alpha_rd;
  logic [ACC_W-1:0] bias;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] score;
  logic             decision;
  logic             error;

  modport master (
    output start, stall_MEM, bias, kern_done, kern_result, alpha_data,
    input  kern_start, kern_sv_idx, alpha_addr, alpha_rd,
           busy, done, score, decision, error
  );

  modport slave (
    input  start, stall_MEM, bias, kern_done, kern_result, alpha_data,
    output kern_start, kern_sv_idx, alpha_addr, alpha_rd,
           busy, done, score, decision, error
  );
endinterface

// File: rtl/svm_kernel_sched.sv
// ---------------------------------------------------------------------------
// svm_kernel_sched
// Sequences NUM_SV kernel evaluations for one SVM classification and
// accumulates score = bias + sum(alpha[i] * K(x, sv[i])) with saturation.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : svm_kernel_sched_if.slave
//     start/bias            -> begin classification, bias sampled at start
//     stall_MEM             -> holds the scheduler in ISSUE
//     kern_start/kern_sv_idx, kern_done/kern_result -> kernel engine
//     alpha_rd/alpha_addr, alpha_data (1-cycle read latency) -> alpha memory
//     busy, done, score, decision, error -> status and result
// Optional feature: define SVM_SCHED_TIMEOUT_EN to bound each WAIT to
// TIMEOUT cycles; a timed-out index sets the sticky error flag and is
// skipped without touching the accumulator.
// Number formats: alpha and kernel are Q8.8, product and accumulator Q.16.
// ---------------------------------------------------------------------------
module svm_kernel_sched #(
  parameter int NUM_SV  = 10,
  parameter int IDX_W   = 4,
  parameter int ACC_W   = 40,
  parameter int TIMEOUT = 1023
) (
  input logic               clk,
  input logic               rst,
  svm_kernel_sched_if.slave bus
);

  // Wide enough for both the ACC_W accumulator and the 33-bit product, plus carry.
  localparam int SUM_W = ((ACC_W > 33) ? ACC_W : 33) + 1;

  if ((2 ** IDX_W) < NUM_SV || TIMEOUT < 1) begin : g_bad_cfg
    $error("svm_kernel_sched: IDX_W too small for NUM_SV or TIMEOUT < 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MAC   = 3'd3,
    S_FINAL = 3'd4
  } state_t;

  // Signed accumulate with clamping to the ACC_W range instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [32:0]      prod);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] max_v;
    logic signed [SUM_W-1:0] min_v;
    max_v = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    min_v = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    sum   = $signed({{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc})
          + $signed({{(SUM_W-33){prod[32]}}, prod});
    if (sum > max_v) begin
      sat_add = max_v[ACC_W-1:0];
    end else if (sum < min_v) begin
      sat_add = min_v[ACC_W-1:0];
    end else begin
      sat_add = sum[ACC_W-1:0];
    end
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      kres_q, kres_d;
  logic [15:0]      alpha_q, alpha_d;
  logic             alpha_vld_q, alpha_vld_d;
  logic             kern_start_q, kern_start_d;
  logic             alpha_rd_q, alpha_rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] score_q, score_d;
  logic             decision_q, decision_d;
  logic             last_sv_s;
  logic [15:0]      alpha_sel_s;
  logic [32:0]      prod_s;
`ifdef SVM_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
`endif

  assign last_sv_s   = (idx_q == IDX_W'(NUM_SV - 1));
  // When the kernel answers one cycle after issue, MAC runs in the very cycle
  // alpha_data is valid, before it has been captured into alpha_q.
  assign alpha_sel_s = alpha_vld_q ? bus.alpha_data : alpha_q;
  assign prod_s      = {{17{alpha_sel_s[15]}}, alpha_sel_s} * {17'd0, kres_q};

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    kres_d       = kres_q;
    alpha_vld_d  = alpha_rd_q;
    alpha_d      = alpha_vld_q ? bus.alpha_data : alpha_q;
    kern_start_d = 1'b0;
    alpha_rd_d   = 1'b0;
    done_d       = 1'b0;
    score_d      = score_q;
    decision_d   = decision_q;
`ifdef SVM_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    error_d      = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          acc_d   = bus.bias;
          idx_d   = {IDX_W{1'b0}};
`ifdef SVM_SCHED_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.stall_MEM) begin
          kern_start_d = 1'b1;
          alpha_rd_d   = 1'b1;
          state_d      = S_WAIT;
`ifdef SVM_SCHED_TIMEOUT_EN
          cnt_d        = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (bus.kern_done) begin
          kres_d  = bus.kern_result;
          state_d = S_MAC;
        end
`ifdef SVM_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Give up on this index: flag it and move on without accumulating.
          error_d = 1'b1;
          if (last_sv_s) begin
            state_d = S_FINAL;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_MAC: begin
        acc_d = sat_add(acc_q, prod_s);
        if (last_sv_s) begin
          state_d = S_FINAL;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FINAL: begin
        score_d    = acc_q;
        decision_d = ~acc_q[ACC_W-1];
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      acc_q        <= {ACC_W{1'b0}};
      kres_q       <= 16'd0;
      alpha_q      <= 16'd0;
      alpha_vld_q  <= 1'b0;
      kern_start_q <= 1'b0;
      alpha_rd_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      score_q      <= {ACC_W{1'b0}};
      decision_q   <= 1'b0;
`ifdef SVM_SCHED_TIMEOUT_EN
      cnt_q        <= {CNT_W{1'b0}};
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      kres_q       <= kres_d;
      alpha_q      <= alpha_d;
      alpha_vld_q  <= alpha_vld_d;
      kern_start_q <= kern_start_d;
      alpha_rd_q   <= alpha_rd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      score_q      <= score_d;
      decision_q   <= decision_d;
`ifdef SVM_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  assign bus.kern_start  = kern_start_q;
  assign bus.kern_sv_idx = idx_q;
  assign bus.alpha_rd    = alpha_rd_q;
  assign bus.alpha_addr  = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.score       = score_q;
  assign bus.decision    = decision_q;
`ifdef SVM_SCHED_TIMEOUT_EN
  assign bus.error       = error_q;
`else
  assign bus.error       = 1'b0;
`endif

endmodule

// File: tb/tb_svm_kernel_sched.sv
// ---------------------------------------------------------------------------
// tb_svm_kernel_sched
// Scoreboard bench for svm_kernel_sched (NUM_SV=2, ACC_W=32, TIMEOUT=8).
// Each classification pushes its hand-computed score/decision/error/latency
// into a queue; a monitor pops and compares whenever done pulses.
// Kernel latency L counts cycles from the ISSUE decision, so kern_done is
// presented in the L-th WAIT cycle (L-1 cycles after kern_start is seen).
// ---------------------------------------------------------------------------
module tb_svm_kernel_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svm_kernel_sched_if #(.IDX_W(4), .ACC_W(32)) bus ();

  svm_kernel_sched #(.NUM_SV(2), .IDX_W(4), .ACC_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] score;
    logic        dec;
    logic        err;
    int          lat;
    int          scyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] amem[16];
  logic [15:0] kmem[16];
  int          kern_lat = 3;
  logic        mute0 = 1'b0;
  logic        kd_model = 1'b0;
  logic        kd_extra = 1'b0;
  logic        kpend = 1'b0;
  int          kcd = 0;
  logic [3:0]  kidx = 4'd0;
  logic        rd_seen;
  logic [3:0]  rd_addr;

  assign bus.kern_done = kd_model | kd_extra;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Kernel engine model: answers kern_start after kern_lat cycles.
  always @(negedge clk) begin
    kd_model = 1'b0;
    if (kpend && kcd > 0) kcd--;
    if (bus.kern_start && !(mute0 && bus.kern_sv_idx == 4'd0)) begin
      kpend = 1'b1;
      kcd   = kern_lat - 1;
      kidx  = bus.kern_sv_idx;
    end
    if (kpend && kcd == 0) begin
      kd_model        = 1'b1;
      bus.kern_result = kmem[kidx];
      kpend           = 1'b0;
    end
  end

  // Alpha memory model: data valid only in the cycle after alpha_rd.
  always @(posedge clk) begin
    rd_seen = bus.alpha_rd;
    rd_addr = bus.alpha_addr;
    #1 bus.alpha_data = rd_seen ? amem[rd_addr] : 16'h5A5A;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("score", 64'(bus.score), 64'(e.score));
        chk("decision", 64'(bus.decision), 64'(e.dec));
        chk("error", 64'(bus.error), 64'(e.err));
        chk("latency", 64'(cyc - e.scyc), 64'(e.lat));
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_kern_start"}, 64'(bus.kern_start), 64'd0);
    chk({tag, "_alpha_rd"}, 64'(bus.alpha_rd), 64'd0);
    chk({tag, "_kern_sv_idx"}, 64'(bus.kern_sv_idx), 64'd0);
    chk({tag, "_alpha_addr"}, 64'(bus.alpha_addr), 64'd0);
    chk({tag, "_score"}, 64'(bus.score), 64'd0);
    chk({tag, "_decision"}, 64'(bus.decision), 64'd0);
    chk({tag, "_error"}, 64'(bus.error), 64'd0);
  endtask

  // mode: 0 plain, 1 stall ISSUE of index 1 for 5 cycles, 2 extra start in
  // WAIT, 3 kern_done together with start, 4 kernel silent for index 0.
  task automatic run_vec(input logic [31:0] b, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] k0, input logic [15:0] k1, input int lat,
                         input logic [31:0] escore, input logic edec, input logic eerr,
                         input int elat, input int mode);
    logic got;
    amem[0] = a0; amem[1] = a1; kmem[0] = k0; kmem[1] = k1;
    kern_lat = lat;
    mute0 = (mode == 4);
    @(negedge clk);
    bus.bias  = b;
    bus.start = 1'b1;
    if (mode == 3) kd_extra = 1'b1;
    exp_q.push_back('{escore, edec, eerr, elat, cyc});
    @(negedge clk);
    bus.start = 1'b0;
    kd_extra  = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    fork
      begin
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
          if (bus.done) got = 1'b1;
          else @(negedge clk);
        end
        if (!got) begin
          chk("done_timeout", 64'd0, 64'd1);
          exp_q.delete();
        end
      end
      begin
        logic seen;
        seen = 1'b0;
        if (mode == 1) begin
          for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            seen = kd_model;
          end
          @(negedge clk);
          @(negedge clk);
          bus.stall_MEM = 1'b1;
          for (int i = 0; i < 5; i++) begin
            chk("no_kern_start_in_stall", 64'(bus.kern_start), 64'd0);
            chk("no_alpha_rd_in_stall", 64'(bus.alpha_rd), 64'd0);
            @(negedge clk);
          end
          bus.stall_MEM = 1'b0;
        end else if (mode == 2) begin
          for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.kern_start;
          end
          bus.start = 1'b1;
          bus.bias  = 32'h1234_5678;
          @(negedge clk);
          bus.start = 1'b0;
          bus.bias  = b;
        end
      end
    join
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall_MEM = 1'b0;
    bus.bias = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // 2*1.0 + (-1)*1.0 = 1.0
    run_vec(32'h0000_0000, 16'h0100, 16'hFF00, 16'h0200, 16'h0100, 3,
            32'h0001_0000, 1'b1, 1'b0, 12, 0);
    // -3.0 + 1.0 + 1.0 = -1.0
    run_vec(32'hFFFD_0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 3,
            32'hFFFF_0000, 1'b0, 1'b0, 12, 0);
    // same as first, 5-cycle stall adds 5 cycles
    run_vec(32'h0000_0000, 16'h0100, 16'hFF00, 16'h0200, 16'h0100, 3,
            32'h0001_0000, 1'b1, 1'b0, 17, 1);
    // L=1: 0.5 + 0.5*4 + 2*0.5 = 3.5
    run_vec(32'h0000_8000, 16'h0080, 16'h0200, 16'h0400, 16'h0080, 1,
            32'h0003_8000, 1'b1, 1'b0, 8, 0);
    // exactly zero score -> decision 1
    run_vec(32'hFFFE_0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 2,
            32'h0000_0000, 1'b1, 1'b0, 10, 0);
    // positive saturation
    run_vec(32'h0000_0000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 1,
            32'h7FFF_FFFF, 1'b1, 1'b0, 8, 0);
    // negative saturation
    run_vec(32'h0000_0000, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 1,
            32'h8000_0000, 1'b0, 1'b0, 8, 0);
    // start during WAIT (with different bias) is ignored
    run_vec(32'hFFFD_0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 3,
            32'hFFFF_0000, 1'b0, 1'b0, 12, 2);

    // reset in MAC aborts the classification
    amem[0] = 16'h0100; amem[1] = 16'h0100; kmem[0] = 16'h0100; kmem[1] = 16'h0100;
    kern_lat = 3;
    mute0 = 1'b0;
    @(negedge clk);
    bus.bias  = 32'h0000_1234;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      seen = kd_model;
    end
    chk("rst_test_kern_done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("mac_reset");
    kd_extra = 1'b1;
    @(negedge clk);
    kd_extra = 1'b0;
    @(negedge clk);
    chk("late_done_busy", 64'(bus.busy), 64'd0);
    chk("late_done_kern_start", 64'(bus.kern_start), 64'd0);

    // normal run after reset, kern_done coincident with start in IDLE
    run_vec(32'h0000_0000, 16'h0100, 16'hFF00, 16'h0200, 16'h0100, 3,
            32'h0001_0000, 1'b1, 1'b0, 12, 3);

`ifdef SVM_SCHED_TIMEOUT_EN
    // index 0 never answered: 8 WAIT cycles, skipped; only 1.0*2.0 counted
    run_vec(32'h0000_0000, 16'h0100, 16'h0100, 16'h0300, 16'h0200, 3,
            32'h0002_0000, 1'b1, 1'b1, 16, 4);
    mute0 = 1'b0;
    // next start clears the sticky error
    run_vec(32'hFFFD_0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 3,
            32'hFFFF_0000, 1'b0, 1'b0, 12, 0);
`endif

    repeat (3) @(negedge clk);
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/svm_kernel_sched.md
SVM_KERNEL_SCHED -- requirements
Module: svm_kernel_sched

Interface
REQ-001 Parameter NUM_SV, default 10, number of support vectors sequenced per classification.
REQ-002 Parameter IDX_W, default 4, width of support-vector index; SHALL satisfy 2**IDX_W >= NUM_SV.
REQ-003 Parameter ACC_W, default 40, signed accumulator width.
REQ-004 Parameter TIMEOUT, default 1023, maximum wait cycles per kernel evaluation.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse, begin classification; ignored unless IDLE.
REQ-008 stall_MEM  in  1  memory stall; while high, no new kernel issue and no alpha read.
REQ-009 kern_start  out  1  one-cycle pulse launching kernel evaluation for kern_sv_idx.
REQ-010 kern_sv_idx  out  IDX_W  support-vector index for current evaluation.
REQ-011 kern_done  in  1  one-cycle pulse, kernel result valid.
REQ-012 kern_result  in  16  unsigned kernel value, Q8.8, valid with kern_done.
REQ-013 alpha_addr  out  IDX_W  alpha coefficient read address.
REQ-014 alpha_data  in  16  signed Q8.8 coefficient, valid one cycle after alpha_addr sampled with alpha_rd.
REQ-015 alpha_rd  out  1  alpha read strobe.
REQ-016 bias  in  ACC_W  signed Q.16 bias, sampled at start.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse, score/decision valid.
REQ-019 score  out  ACC_W  signed Q.16 final decision value, held until next start.
REQ-020 decision  out  1  1 when score >= 0, held with score.
REQ-021 error  out  1  sticky timeout flag, cleared on start or reset.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, MAC, FINAL; one state per cycle except WAIT.
REQ-023 IDLE->ISSUE on start; acc loaded with bias, sv index cleared to 0, error cleared.
REQ-024 ISSUE: if stall_MEM low, pulse kern_start and alpha_rd with current index, go WAIT; if high, remain ISSUE with no pulses.
REQ-025 Captured alpha_data registered on cycle after alpha_rd; kernel latency >= 1 cycle guaranteed by kernel.
REQ-026 WAIT->MAC on kern_done; kern_result registered; kern_done outside WAIT ignored.
REQ-027 MAC: acc <= sat(acc + sign-extended alpha*kern_result), product signed 33-bit Q16.16; saturate to ACC_W signed max/min, no wrap.
REQ-028 MAC->ISSUE with index+1 if index < NUM_SV-1, else MAC->FINAL.
REQ-029 FINAL: score <= acc, decision <= ~acc[ACC_W-1], done pulses same cycle as registered outputs become valid, go IDLE.
REQ-030 Latency with no stall and kernel latency L: NUM_SV*(L+2)+2 cycles from start to done.
REQ-031 start asserted while busy SHALL be ignored with no state change.
REQ-032 kern_done and start same cycle in IDLE: start honored, kern_done ignored.

Reset
REQ-033 On rst: state IDLE, busy 0, done 0, kern_start 0, alpha_rd 0, kern_sv_idx 0, alpha_addr 0, score 0, decision 0, error 0, acc 0.
REQ-034 rst mid-classification aborts immediately; late kern_done after reset ignored.

Configuration
REQ-035 Macro SVM_SCHED_TIMEOUT_EN: when defined, WAIT counts cycles; at TIMEOUT without kern_done, set error, skip MAC for that index (acc unchanged), advance as in REQ-028.
REQ-036 Without SVM_SCHED_TIMEOUT_EN: WAIT waits indefinitely, error tied 0, no counter logic.

Verification
REQ-037 NUM_SV=2, alpha={0x0100,0xFF00}, kern={0x0200,0x0100}, bias=0, L=3 -> score=0x10000 (1.0), decision 1, done at cycle 2*(5)+2=12.
REQ-038 bias=-0x30000, alpha all 0x0100, kern all 0x0100, NUM_SV=2 -> score=-0x10000, decision 0.
REQ-039 stall_MEM high 5 cycles during ISSUE of index 1 -> no kern_start during stall, result identical, done 5 cycles later.
REQ-040 start pulsed during WAIT and rst asserted in MAC -> second start ignored; after rst all outputs at REQ-033 values, next start runs normally.
REQ-041 With SVM_SCHED_TIMEOUT_EN, TIMEOUT=8, kernel never responds for index 0 -> error 1 after 8 WAIT cycles, index 1 still issued, score excludes index 0.
REQ-042 alpha=0x7FFF, kern=0xFFFF, NUM_SV=10, ACC_W=32 -> acc saturates at 0x7FFFFFFF, no wrap, decision 1.
